// File: rtl/filter_stream_pkg.sv
// rtl/filter_stream_pkg.sv - shared defaults, state encoding and width helper for the sample feeder
package filter_stream_pkg;

    localparam int DEFAULT_N     = 7;
    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_DIV_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - DEPTH-entry sample buffer with synchronous push/pop and occupancy count
module sample_fifo
    import filter_stream_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    output logic [W-1:0]            pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level
);

    localparam int PW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    assign full     = (level == (PW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign pop_data = mem[rptr];

    // Storage carries no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (PW+1)'(1);
                2'b01:   level <= level - (PW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/filter_sample_feeder.sv
// rtl/filter_sample_feeder.sv - buffers host samples and replays them onto the filter x port at a set rate
module filter_sample_feeder
    import filter_stream_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    start,
    input  logic                    stop,
    input  logic [DIV_W-1:0]        rate_div,
    output logic [N:0]              x,
    output logic                    x_valid,
    output logic                    busy,
    output logic                    underflow,
    output logic [clog2(DEPTH):0]   level
);

    state_t            state;
    state_t            state_next;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic              tick;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [N:0]        head;

    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign busy     = (state == ST_RUN);

    // A start or stop pulse restarts the divider, so no tick fires in that cycle.
    assign tick = (state == ST_RUN) && !start && !stop && (cnt == div_q);
    assign pop  = tick && !empty;

    sample_fifo #(
        .W     (N + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = ST_IDLE;
        end else if (start) begin
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else begin
            if (start) begin
                div_q <= rate_div;
            end
            if (start || stop || tick) begin
                cnt <= '0;
            end else if (state == ST_RUN) begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            x_valid   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            x_valid <= pop;
            if (pop) begin
                x <= head;
            end
            if (start) begin
                underflow <= 1'b0;
            end else if (tick && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_filter_sample_feeder.sv
// tb/tb_filter_sample_feeder.sv - directed vector bench for filter_sample_feeder
module tb_filter_sample_feeder;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        stop;
    logic [7:0]  rate_div;
    logic [7:0]  x;
    logic        x_valid;
    logic        busy;
    logic        underflow;
    logic [4:0]  level;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       st;
        logic       sp;
        logic [7:0] rd;
        logic [7:0] ex;
        logic       exv;
        logic       eb;
        logic       eu;
        logic [4:0] el;
        logic       er;
    } vec_t;

    vec_t vecs [24];

    filter_sample_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
        .stop      (stop),
        .rate_div  (rate_div),
        .x         (x),
        .x_valid   (x_valid),
        .busy      (busy),
        .underflow (underflow),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ex, input logic exv, input logic eb,
                           input logic eu, input logic [4:0] el, input logic er);
        chk({tag, ".x"}, 32'(x), 32'(ex));
        chk({tag, ".x_valid"}, 32'(x_valid), 32'(exv));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".underflow"}, 32'(underflow), 32'(eu));
        chk({tag, ".level"}, 32'(level), 32'(el));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic st, input logic sp,
                                input logic [7:0] rd, input logic [7:0] ex, input logic exv,
                                input logic eb, input logic eu, input logic [4:0] el, input logic er);
        vec_t r;
        r.d = d; r.v = v; r.st = st; r.sp = sp; r.rd = rd;
        r.ex = ex; r.exv = exv; r.eb = eb; r.eu = eu; r.el = el; r.er = er;
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //            d     v  st sp rd    x     xv b  uf lvl ry
        vecs[0]  = mk(8'hA5, 1, 0, 0, 8'd0, 8'h00, 0, 0, 0, 1,  1);
        vecs[1]  = mk(8'h3C, 1, 0, 0, 8'd0, 8'h00, 0, 0, 0, 2,  1);
        vecs[2]  = mk(8'hFF, 1, 0, 0, 8'd0, 8'h00, 0, 0, 0, 3,  1);
        vecs[3]  = mk(8'h00, 0, 1, 0, 8'd0, 8'h00, 0, 1, 0, 3,  1);
        vecs[4]  = mk(8'h00, 0, 0, 0, 8'd0, 8'hA5, 1, 1, 0, 2,  1);
        vecs[5]  = mk(8'h00, 0, 0, 0, 8'd0, 8'h3C, 1, 1, 0, 1,  1);
        vecs[6]  = mk(8'h00, 0, 0, 0, 8'd0, 8'hFF, 1, 1, 0, 0,  1);
        vecs[7]  = mk(8'h00, 0, 0, 0, 8'd0, 8'hFF, 0, 1, 1, 0,  1);
        vecs[8]  = mk(8'h42, 1, 0, 0, 8'd0, 8'hFF, 0, 1, 1, 1,  1);
        vecs[9]  = mk(8'h00, 0, 1, 1, 8'd0, 8'hFF, 0, 0, 0, 1,  1);
        vecs[10] = mk(8'h00, 0, 0, 0, 8'd0, 8'hFF, 0, 0, 0, 1,  1);
        vecs[11] = mk(8'h11, 1, 0, 0, 8'd0, 8'hFF, 0, 0, 0, 2,  1);
        vecs[12] = mk(8'h22, 1, 0, 0, 8'd0, 8'hFF, 0, 0, 0, 3,  1);
        vecs[13] = mk(8'h33, 1, 0, 0, 8'd0, 8'hFF, 0, 0, 0, 4,  1);
        vecs[14] = mk(8'h00, 0, 1, 0, 8'd3, 8'hFF, 0, 1, 0, 4,  1);
        vecs[15] = mk(8'h00, 0, 0, 0, 8'd0, 8'hFF, 0, 1, 0, 4,  1);
        vecs[16] = mk(8'h00, 0, 0, 0, 8'd0, 8'hFF, 0, 1, 0, 4,  1);
        vecs[17] = mk(8'h00, 0, 0, 0, 8'd0, 8'hFF, 0, 1, 0, 4,  1);
        vecs[18] = mk(8'h00, 0, 0, 0, 8'd0, 8'h42, 1, 1, 0, 3,  1);
        vecs[19] = mk(8'h00, 0, 0, 0, 8'd0, 8'h42, 0, 1, 0, 3,  1);
        vecs[20] = mk(8'h00, 0, 0, 0, 8'd0, 8'h42, 0, 1, 0, 3,  1);
        vecs[21] = mk(8'h00, 0, 0, 0, 8'd0, 8'h42, 0, 1, 0, 3,  1);
        vecs[22] = mk(8'h00, 0, 0, 0, 8'd0, 8'h11, 1, 1, 0, 2,  1);
        vecs[23] = mk(8'h00, 0, 0, 1, 8'd0, 8'h11, 0, 0, 0, 2,  1);

        rst = 1'b1;
        in_data = '0; in_valid = 1'b0; start = 1'b0; stop = 1'b0; rate_div = '0;
        step();
        step();
        chk_all("reset", 8'h00, 0, 0, 0, 5'd0, 0);
        rst = 1'b0;
        #1;
        chk("reset.in_ready_release", 32'(in_ready), 32'd1);

        for (int i = 0; i < 24; i++) begin
            in_data = vecs[i].d; in_valid = vecs[i].v;
            start = vecs[i].st; stop = vecs[i].sp; rate_div = vecs[i].rd;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].exv, vecs[i].eb,
                    vecs[i].eu, vecs[i].el, vecs[i].er);
        end

        // Reset during RUN with three samples buffered
        in_data = 8'h55; in_valid = 1'b1; start = 1'b0; stop = 1'b0; rate_div = 8'd0;
        step();
        in_valid = 1'b0; start = 1'b1; rate_div = 8'd200;
        step();
        start = 1'b0;
        step();
        chk_all("prerst", 8'h11, 0, 1, 0, 5'd3, 1);
        rst = 1'b1;
        #2;
        chk_all("midrst", 8'h00, 0, 0, 0, 5'd0, 0);
        step();
        rst = 1'b0;
        #1;
        chk_all("postrst", 8'h00, 0, 0, 0, 5'd0, 1);

        // Fill to full, attempt an overflow write
        for (int i = 1; i <= 16; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            step();
            chk($sformatf("fill%0d.level", i), 32'(level), 32'(i));
            chk($sformatf("fill%0d.in_ready", i), 32'(in_ready), (i < 16) ? 32'd1 : 32'd0);
        end
        in_data = 8'h11;
        step();
        chk("overflow.level", 32'(level), 32'd16);
        chk("overflow.in_ready", 32'(in_ready), 32'd0);

        // Pop at full with a pending write: the write stays blocked
        in_data = 8'h77; start = 1'b1; rate_div = 8'd0;
        step();
        start = 1'b0;
        chk_all("fullstart", 8'h00, 0, 1, 0, 5'd16, 0);
        step();
        in_valid = 1'b0;
        chk_all("fullpop", 8'h01, 1, 1, 0, 5'd15, 1);
        for (int i = 2; i <= 16; i++) begin
            step();
            chk_all($sformatf("drain%0d", i), 8'(i), 1, 1, 0, 5'(16 - i), 1);
        end
        step();
        chk_all("drain_under", 8'h10, 0, 1, 1, 5'd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
